// File: rtl/servo_ramp.sv
// rtl/servo_ramp.sv - rate-limited servo position ramp feeding the PWM stage
// Optional macro SERVO_IDLE_OFF_EN: release pos_en after IDLE_OFF_CYCLES idle cycles.
`timescale 1ns/1ps
module servo_ramp #(
    parameter int STEP_CYCLES   = 200_000,
    parameter int STEP_SIZE     = 1,
    parameter int SETTLE_CYCLES = 1_000_000,
    parameter int POS_MIN       = 0,
    parameter int POS_MAX       = 41,
    parameter int POS_HOME      = 8
`ifdef SERVO_IDLE_OFF_EN
    ,
    parameter int IDLE_OFF_CYCLES = 50_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_target,
    input  logic        stop,
    output logic [15:0] pos,
    output logic        pos_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

    localparam logic [15:0] P_MIN       = 16'(POS_MIN);
    localparam logic [15:0] P_MAX       = 16'(POS_MAX);
    localparam logic [15:0] P_HOME      = 16'(POS_HOME);
    localparam logic [15:0] STEP        = 16'(STEP_SIZE);
    localparam logic [19:0] TICK_LAST   = 20'(STEP_CYCLES - 1);
    localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [15:0] target_reg;
    logic [19:0] tick_cnt;
    logic [19:0] settle_cnt;
    logic [15:0] cmd_clamped;
    logic [15:0] step_tgt;
    logic [15:0] diff;
    logic        accept;
    logic        tick_wrap;

`ifdef SERVO_IDLE_OFF_EN
    localparam logic [31:0] IDLE_OFF_LAST = 32'(IDLE_OFF_CYCLES - 1);
    logic [31:0] idle_cnt;
`endif

    // A same-cycle stop outside IDLE wins over the handshake.
    always_comb begin
        cmd_clamped = (cmd_target > P_MAX) ? P_MAX :
                      ((cmd_target > P_MIN) ? cmd_target : P_MIN);
        accept      = cmd_valid && cmd_ready && !(stop && (state != IDLE));
        tick_wrap   = (tick_cnt == TICK_LAST);
        step_tgt    = accept ? cmd_clamped : target_reg;
        diff        = (step_tgt > pos) ? (step_tgt - pos) : (pos - step_tgt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pos        <= P_HOME;
            pos_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
            target_reg <= P_HOME;
            tick_cnt   <= '0;
            settle_cnt <= '0;
`ifdef SERVO_IDLE_OFF_EN
            idle_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                target_reg <= cmd_clamped;
                pos_en     <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                        if (cmd_clamped == pos) begin
                            state      <= SETTLE;
                            cmd_ready  <= 1'b0;
                            settle_cnt <= '0;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                        tick_cnt   <= '0;
                        settle_cnt <= '0;
                    end else begin
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + 20'd1;
                        if (accept && (cmd_clamped == pos)) begin
                            state      <= SETTLE;
                            cmd_ready  <= 1'b0;
                            settle_cnt <= '0;
                        end else if (tick_wrap) begin
                            // Final partial step lands exactly on target, never past it.
                            if (diff <= STEP) begin
                                pos        <= step_tgt;
                                state      <= SETTLE;
                                cmd_ready  <= 1'b0;
                                settle_cnt <= '0;
                            end else begin
                                pos <= (step_tgt > pos) ? (pos + STEP) : (pos - STEP);
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                        tick_cnt   <= '0;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SERVO_IDLE_OFF_EN
            if (accept || (state != IDLE)) begin
                idle_cnt <= '0;
            end else if (pos_en) begin
                if (idle_cnt == IDLE_OFF_LAST) begin
                    pos_en   <= 1'b0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_servo_ramp.sv
// tb/tb_servo_ramp.sv - scoreboard bench for servo_ramp
// Stimulus pushes expected pos/done events; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_servo_ramp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_target;
    logic        stop;
    logic [15:0] pos;
    logic        pos_en;
    logic        busy;
    logic        done;

    servo_ramp #(
        .STEP_CYCLES(4),
        .STEP_SIZE(1),
        .SETTLE_CYCLES(8),
        .POS_MIN(0),
        .POS_MAX(41),
        .POS_HOME(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_target(cmd_target),
        .stop(stop),
        .pos(pos),
        .pos_en(pos_en),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } evt_t;

    evt_t exp_q[$];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   last_pos = 8;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_evt(input int kind, input int val);
        evt_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: actual kind %0d val %0d cycle %0d required none",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: actual kind %0d val %0d cycle %0d required kind %0d val %0d cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // kind 0 = pos change, kind 1 = done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            last_pos = int'(pos);
        end else begin
            if (int'(pos) != last_pos) begin
                mon_evt(0, int'(pos));
                last_pos = int'(pos);
            end
            if (done) mon_evt(1, int'(pos));
        end
    end

    task automatic push_evt(input int kind, input int val, input int c);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // One unit step every 4 cycles from first_step; done 8 cycles after the last step.
    task automatic push_ramp(input int from, input int to, input int first_step, input bit with_done);
        int p = from;
        int c = first_step;
        while (p != to) begin
            p = (to > p) ? p + 1 : p - 1;
            push_evt(0, p, c);
            c += 4;
        end
        if (with_done) push_evt(1, to, c - 4 + 8);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int t, output int tacc);
        chk("cmd_ready_before_send", int'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_target = 16'(t);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tacc      = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int t2;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        stop       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_pos", int'(pos), 8);
        chk("reset_pos_en", int'(pos_en), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(posedge clk);
        #1;

        // 8 -> 12
        send(12, t);
        push_ramp(8, 12, t + 4, 1'b1);
        chk("accept_pos_en", int'(pos_en), 1);
        chk("accept_busy", int'(busy), 1);
        goto(t + 24);
        chk("done_cycle_ready", int'(cmd_ready), 0);
        chk("done_cycle_done", int'(done), 1);
        goto(t + 25);
        chk("after_done_ready", int'(cmd_ready), 1);
        chk("after_done_busy", int'(busy), 0);

        // 12 -> 40, then 200 clamps to 41
        send(40, t);
        push_ramp(12, 40, t + 4, 1'b1);
        goto(t + 121);
        send(200, t);
        push_ramp(40, 41, t + 4, 1'b1);
        goto(t + 13);
        chk("clamp_pos", int'(pos), 41);

        // target equals current position
        send(41, t);
        push_evt(1, 41, t + 8);
        chk("same_target_ready", int'(cmd_ready), 0);
        chk("same_target_busy", int'(busy), 1);
        goto(t + 9);
        chk("same_target_pos", int'(pos), 41);

        // reset mid-ramp
        send(30, t);
        push_ramp(41, 39, t + 4, 1'b0);
        goto(t + 9);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midramp_reset_pos", int'(pos), 8);
        chk("midramp_reset_pos_en", int'(pos_en), 0);
        chk("midramp_reset_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 8 -> 20, retarget to 5 at pos 11
        send(20, t);
        push_ramp(8, 11, t + 4, 1'b0);
        goto(t + 12);
        chk("retarget_pos", int'(pos), 11);
        send(5, t2);
        chk("retarget_accept_cycle", t2, t + 13);
        push_ramp(11, 5, t + 16, 1'b1);
        goto(t + 45);

        // stop at pos 10 with a simultaneous command
        send(20, t);
        push_ramp(5, 10, t + 4, 1'b0);
        goto(t + 20);
        stop       = 1'b1;
        cmd_valid  = 1'b1;
        cmd_target = 16'd30;
        @(posedge clk);
        #1;
        stop      = 1'b0;
        cmd_valid = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_pos", int'(pos), 10);
        chk("stop_ready", int'(cmd_ready), 1);
        goto(cyc + 12);
        chk("stop_hold_pos", int'(pos), 10);
        chk("stop_hold_busy", int'(busy), 0);
        chk("stop_pos_en", int'(pos_en), 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
